time_display_scan: RTL and testbench
====================================

Name: time_display_scan

Overview:
Consumer end of the clock's BCD time path. Takes the packed BCD hour and minute values from the hour and minute counters and drives a 4-digit, common-anode, multiplexed 7-segment display. Each frame it latches a tear-free snapshot, time-multiplexes the four digits, and blinks the field currently being set. It sits between the counter chain and the board pins.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot (2 minimum)
BLINK_FRAMES, 64, full scan frames per blink half-period (1 minimum)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hour_bcd  in  8  packed BCD hours: [7:4] is the tens digit, [3:0] is the units digit
min_bcd  in  8  packed BCD minutes, same layout
set_ena  in  1  set mode active; enables blinking
set_sel  in  1  field being set: 0 = minutes, 1 = hours
an_n  out  4  digit anodes, active low; [0] = minute units, [3] = hour tens
seg_n  out  7  segments, active low; [0] = a … [6] = g
dp_n  out  1  decimal point, active low; used as the colon on digit 2
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset values (asynchronous on reset_n low): an_n = 4'b1111, seg_n = 7'h7F, dp_n = 1, frame_tick = 0, digit index = 0, scan counter = 0, blink counter = 0, blink phase = 1 (visible), snapshot = 16'h0000.
- Scan counter runs 0 .. SCAN_DIV-1 and wraps.
- On wrap, digit index advances 0→1→2→3→0.
- On the wrap into index 0: the snapshot latches {hour_bcd, min_bcd}, and frame_tick pulses for that cycle.
  - Inputs are sampled only at this point, so ripple updates from the counters are never shown mid-frame.
  - Input-to-display latency is at most one frame (4·SCAN_DIV cycles).
- Anti-ghosting: in scan-count slot 0 of every digit, an_n = 4'b1111 (all off).
  - During slots 1 .. SCAN_DIV-1, exactly one bit of an_n is low, selected by digit index.
- seg_n and dp_n are registered outputs, aligned with an_n in the same cycle.
- Digit mapping: 0 = snap[3:0], 1 = snap[7:4], 2 = snap[11:8], 3 = snap[15:12].
- Decoding:
  - Nibbles 0..9 map to standard glyphs; '0' = 7'b1000000, '1' = 7'b1111001, '8' = 7'b0000000.
  - Nibbles 10..15 show '-' (7'b0111111).
- Blink timing: blink counter increments once per frame. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
- Blink blanking:
  - If set_ena = 1 and blink phase = 0, the digits of the selected field are blanked: seg_n = 7'h7F.
  - set_sel = 0 blanks digits 0–1; set_sel = 1 blanks digits 2–3.
  - Their anodes still scan.
  - set_ena = 0 forces no blanking, regardless of blink phase.
- Colon: dp_n = ~blink_phase while digit 2 is active. dp_n = 1 on all other digits.
- set_ena and set_sel are sampled every cycle; they are not snapshotted.
- A mid-operation reset returns all state to the reset values immediately. After release, the first frame_tick occurs 4·SCAN_DIV cycles later.

Optional Feature:
Macro HOUR_LEADING_ZERO_BLANK_EN.
- Defined: when snap[15:12] == 4'h0, digit 3 shows blank (7'h7F) instead of '0', giving 9:05 rather than 09:05.
- Undefined: digit 3 always shows its decoded value.

Decomposition:
- Shared package time_disp_pkg holds:
  - segment glyph constants: SEG_BLANK, SEG_DASH, and the 10-entry digit table;
  - digit-index constants DIG_MIN_U, DIG_MIN_T, DIG_HR_U, DIG_HR_T.
- One natural sub-module: bcd_to_seg7, a combinational nibble-to-active-low-segment decoder including the dash for invalid values.

Test Plan:
(All scenarios use SCAN_DIV = 4, BLINK_FRAMES = 2.)
- Reset then release; hour_bcd = 8'h12, min_bcd = 8'h34 → after the first frame_tick, the digit sequence is an_n 1110/1101/1011/0111 with seg_n = '4', '3', '2', '1'. an_n = 1111 in each slot 0.
- Change min_bcd from 8'h34 to 8'h35 mid-frame → the current frame still shows '4' on digit 0; the next frame shows '5'.
- min_bcd = 8'h3C → digit 0 shows 7'b0111111 ('-'). All other digits are unaffected.
- set_ena = 1, set_sel = 1 → digits 2–3 show 7'h7F for 2 frames, then their glyphs for 2 frames, repeating. Digits 0–1 are constant. dp_n on digit 2 toggles with the same period.
- Assert reset_n low mid-slot for 3 cycles → outputs return to reset values asynchronously. After release, frame_tick first pulses 16 cycles later.
- With HOUR_LEADING_ZERO_BLANK_EN defined and hour_bcd = 8'h09 → digit 3 is 7'h7F. Undefined → digit 3 is 7'b1000000.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared constants for the time display path: active-low segment glyphs and digit positions.
package time_disp_pkg;

  // Segment vectors are active low, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    DIG_MIN_U = 2'd0,
    DIG_MIN_T = 2'd1,
    DIG_HR_U  = 2'd2,
    DIG_HR_T  = 2'd3
  } digit_e;

  function automatic logic is_hour_digit(input digit_e d);
    return (d == DIG_HR_U) || (d == DIG_HR_T);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal nibbles show a dash.
module bcd_to_seg7
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_DASH;
    if (bcd_i <= 4'd9) begin
      seg_n_o = SEG_DIGITS[bcd_i];
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed 4-digit common-anode display driver with per-frame time snapshot and field blinking.
// Optional: define HOUR_LEADING_ZERO_BLANK_EN to blank a leading zero in the hour tens digit.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic       set_ena,
  input  logic       set_sel,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_q, scan_d;
  digit_e             dig_q, dig_d;
  logic [15:0]        snap_q, snap_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;

  logic [3:0] an_n_q, an_n_d;
  logic [6:0] seg_n_q, seg_n_d;
  logic       dp_n_q, dp_n_d;
  logic       tick_q, tick_d;

  logic       scan_wrap, frame_wrap;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q      <= '0;
      dig_q       <= DIG_MIN_U;
      snap_q      <= 16'h0000;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      an_n_q      <= 4'b1111;
      seg_n_q     <= SEG_BLANK;
      dp_n_q      <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      dig_q       <= dig_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      tick_q      <= tick_d;
    end
  end

  // The snapshot only moves at the frame boundary, so counter ripple never shows mid-frame.
  always_comb begin
    scan_wrap   = (scan_q == SCAN_LAST);
    frame_wrap  = scan_wrap && (dig_q == DIG_HR_T);
    scan_d      = scan_wrap ? '0 : scan_q + 1'b1;
    dig_d       = scan_wrap ? digit_e'(dig_q + 2'd1) : dig_q;
    snap_d      = frame_wrap ? {hour_bcd, min_bcd} : snap_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (dig_d)
      DIG_MIN_U: nibble = snap_d[3:0];
      DIG_MIN_T: nibble = snap_d[7:4];
      DIG_HR_U:  nibble = snap_d[11:8];
      default:   nibble = snap_d[15:12];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (nibble),
    .seg_n_o (glyph)
  );

  // Outputs are computed from next state so pins line up with the registered scan position.
  always_comb begin
    blank = set_ena && !blink_ph_d &&
            (set_sel ? is_hour_digit(dig_d) : !is_hour_digit(dig_d));
`ifdef HOUR_LEADING_ZERO_BLANK_EN
    if ((dig_d == DIG_HR_T) && (snap_d[15:12] == 4'h0)) begin
      blank = 1'b1;
    end
`endif
    an_n_d  = (scan_d == '0) ? 4'b1111 : ~(4'b0001 << dig_d);
    seg_n_d = blank ? SEG_BLANK : glyph;
    dp_n_d  = (dig_d == DIG_HR_U) ? ~blink_ph_d : 1'b1;
    tick_d  = frame_wrap;
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: an arithmetic time-slot model feeds an expected queue.
module tb_time_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] hour_bcd = 8'h12;
  logic [7:0] min_bcd = 8'h34;
  logic       set_ena = 1'b0;
  logic       set_sel = 1'b0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Expected word: [13] segment/dp valid, [12] tick, [11] dp, [10:4] seg, [3:0] an.
  logic [13:0] exp_q[$];
  logic [6:0]  glyph_tbl[16];
  int          t = 0;
  logic [15:0] m_snap = 16'h0000;

  time_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .set_ena    (set_ena),
    .set_sel    (set_sel),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in time is derived purely from the number of clock edges since reset release.
  always @(posedge clk) begin
    if (reset_n) begin
      int slot, dig, frame;
      logic phase, tick, blank, dp;
      logic [3:0] nib, an;
      logic [6:0] seg;
      t++;
      slot  = t % SD;
      dig   = (t / SD) % 4;
      frame = t / (4 * SD);
      tick  = (slot == 0) && (dig == 0);
      if (tick) m_snap = {hour_bcd, min_bcd};
      phase = ((frame / BF) % 2) == 0;
      nib   = 4'((m_snap >> (4 * dig)) & 16'hF);
      blank = set_ena && !phase && (set_sel ? (dig >= 2) : (dig <= 1));
`ifdef HOUR_LEADING_ZERO_BLANK_EN
      if (dig == 3 && nib == 4'h0) blank = 1'b1;
`endif
      seg = blank ? 7'h7F : glyph_tbl[nib];
      dp  = (dig == 2) ? !phase : 1'b1;
      an  = (slot == 0) ? 4'b1111 : ~(4'b0001 << dig);
      exp_q.push_back({(slot != 0), tick, dp, seg, an});
    end
  end

  // ---------------- monitor ----------------
  always begin
    @(posedge clk);
    #1;
    if (reset_n && exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      check("an_n", int'(an_n), int'(e[3:0]));
      check("frame_tick", int'(frame_tick), int'(e[12]));
      if (e[13]) begin
        check("seg_n", int'(seg_n), int'(e[10:4]));
        check("dp_n", int'(dp_n), int'(e[11]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n, input bit rnd);
    repeat (n) begin
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) hour_bcd = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) min_bcd  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 31) == 0) set_ena  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 31) == 0) set_sel  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an_n"}, int'(an_n), 'hF);
    check({tag, "_seg_n"}, int'(seg_n), 'h7F);
    check({tag, "_dp_n"}, int'(dp_n), 1);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  task automatic mid_reset(input int hold);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    t = 0;
    m_snap = 16'h0000;
    #1;
    check_reset_vals("async_rst");
    repeat (hold) @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    glyph_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                  7'b0111111};
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    run_cycles(3 * 4 * SD, 1'b0);       // 12:34 steady
    run_cycles(5, 1'b0);
    min_bcd = 8'h35;                     // mid-frame change
    run_cycles(3 * 4 * SD, 1'b0);
    min_bcd = 8'h3C;                     // invalid minute units
    run_cycles(2 * 4 * SD, 1'b0);
    min_bcd = 8'h34;
    set_ena = 1'b1;
    set_sel = 1'b1;
    run_cycles(10 * 4 * SD, 1'b0);
    set_sel = 1'b0;
    run_cycles(8 * 4 * SD, 1'b0);
    set_ena = 1'b0;
    hour_bcd = 8'h09;                    // leading-zero hour
    run_cycles(3 * 4 * SD, 1'b0);

    run_cycles(7, 1'b0);
    mid_reset(3);
    run_cycles(3 * 4 * SD, 1'b0);

    run_cycles(1500, 1'b1);
    mid_reset(3);
    run_cycles(800, 1'b1);
    run_cycles(2, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
